// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The master issues operations and sees busy/done plus the HI/LO registers.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, abort,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, abort,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO ownership; WIDTH+1 cycles start-to-done, MTHI/MTLO in one.
// No queueing: requests arriving while busy are dropped, so the pipeline must hold on busy.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_rs_raw;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // op[0] clear means signed for all four arithmetic opcodes
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_r;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_rs_neg = ~bus.op[0] & bus.rs_data[WIDTH-1];
    assign w_rt_neg = ~bus.op[0] & bus.rt_data[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? -bus.rs_data : bus.rs_data;
    assign w_rt_mag = w_rt_neg ? -bus.rt_data : bus.rt_data;

    // Multiply: upper half accumulates, multiplier shifts out of the low half
    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                      + (r_prod[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, quotient bits shift into the low half
    assign w_div_r    = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    assign w_div_diff = w_div_r - {1'b0, r_a};
    assign w_div_next = w_div_diff[WIDTH]
                      ? {w_div_r[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
                      : {w_div_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};

    assign w_prod_fix = r_neg_q ? -r_prod : r_prod;
    assign w_quot     = r_neg_q ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
    assign w_rem      = r_neg_r ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_a      <= '0;
            r_prod   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_rs_raw <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        if (!bus.op[2]) begin
                            r_is_div <= bus.op[1];
                            r_a      <= bus.op[1] ? w_rt_mag : w_rs_mag;
                            r_prod   <= {{WIDTH{1'b0}}, (bus.op[1] ? w_rs_mag : w_rt_mag)};
                            r_neg_q  <= w_rs_neg ^ w_rt_neg;
                            r_neg_r  <= w_rs_neg;
                            r_dz     <= bus.op[1] && (bus.rt_data == '0);
                            r_rs_raw <= bus.rs_data;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_CALC;
                        end else if (!bus.op[1]) begin
                            if (bus.op[0]) r_lo <= bus.rs_data;
                            else           r_hi <= bus.rs_data;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_prod <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (!bus.abort) begin
                        r_done <= 1'b1;
                        if (r_dz) begin
                            r_hi <= r_rs_raw;
                            r_lo <= '1;
                        end else if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: issued ops push expected HI/LO and done cycle,
// a negedge monitor pops and compares whenever done is seen.
module tb_mul_div_unit;
    localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                           OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t m_e;
    vec_t vq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_div_unit_if #(.WIDTH(32)) bus();
    mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                m_e = sb.pop_front();
                chk("result_hi", 64'(bus.hi), 64'(m_e.hi));
                chk("result_lo", 64'(bus.lo), 64'(m_e.lo));
                chk("done_cycle", 64'(cyc), 64'(m_e.cyc));
                chk("busy_at_done", 64'(bus.busy), 64'd0);
            end
        end
    end

    // Called right after a negedge; returns at the negedge following the start edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input bit push, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = rs;
        bus.rt_data = rt;
        if (push) begin
            e.hi  = eh;
            e.lo  = el;
            e.cyc = cyc + 34;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vq.push_back({OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        vq.push_back({OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1});
        vq.push_back({OP_MULT,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6});
        vq.push_back({OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
        vq.push_back({OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000});
        vq.push_back({OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
        vq.push_back({OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
        vq.push_back({OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
        vq.push_back({OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF});
        vq.push_back({OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF});
        vq.push_back({OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF});

        // Reset with a request held: must be ignored
        reset = 1'b1;
        bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_data = 32'hA5A5A5A5;
        bus.rt_data = '0; bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_hi", 64'(bus.hi), 64'd0);
        chk("reset_lo", 64'(bus.lo), 64'd0);
        bus.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        foreach (vq[i]) begin
            issue(vq[i].op, vq[i].rs, vq[i].rt, 1'b1, vq[i].eh, vq[i].el);
            if (i == 0) chk("busy_after_start", 64'(bus.busy), 64'd1);
            drain();
        end

        // MTHI then MTLO back-to-back
        issue(OP_MTHI, 32'h12345678, '0, 1'b0, '0, '0);
        chk("mthi_hi", 64'(bus.hi), 64'h12345678);
        chk("mthi_busy", 64'(bus.busy), 64'd0);
        issue(OP_MTLO, 32'h9ABCDEF0, '0, 1'b0, '0, '0);
        chk("mtlo_lo", 64'(bus.lo), 64'h9ABCDEF0);
        chk("mtlo_hi_kept", 64'(bus.hi), 64'h12345678);

        // MTHI/MTLO while busy are dropped
        issue(OP_MULTU, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
        issue(OP_MTHI, 32'hDEADBEEF, '0, 1'b0, '0, '0);
        chk("busy_mthi_hi", 64'(bus.hi), 64'h12345678);
        issue(OP_MTLO, 32'hCAFEF00D, '0, 1'b0, '0, '0);
        chk("busy_mtlo_lo", 64'(bus.lo), 64'h9ABCDEF0);
        drain();

        // New start accepted in the done cycle
        issue(OP_MULTU, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12);
        repeat (33) @(negedge clk);
        chk("done_cycle_seen", 64'(bus.done), 64'd1);
        issue(OP_DIVU, 32'd13, 32'd4, 1'b1, 32'd1, 32'd3);
        drain();

        // Abort mid-divide: no done, HI/LO untouched
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, '0, '0);
        repeat (9) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_hi", 64'(bus.hi), 64'd1);
        chk("abort_lo", 64'(bus.lo), 64'd3);
        repeat (40) @(negedge clk);
        chk("abort_hi_later", 64'(bus.hi), 64'd1);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
        drain();

        // Abort in idle and 11x ops change nothing
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("idle_abort_busy", 64'(bus.busy), 64'd0);
        issue(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0, '0);
        issue(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0, '0);
        chk("noop_busy", 64'(bus.busy), 64'd0);
        chk("noop_hi", 64'(bus.hi), 64'd2);
        chk("noop_lo", 64'(bus.lo), 64'd14);

        // Reset mid-CALC with a request held
        issue(OP_MULTU, 32'd7, 32'd7, 1'b0, '0, '0);
        repeat (5) @(negedge clk);
        chk("calc_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        bus.start = 1'b1; bus.op = OP_MTLO; bus.rs_data = 32'h55;
        @(negedge clk);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_hi", 64'(bus.hi), 64'd0);
        chk("midrst_lo", 64'(bus.lo), 64'd0);
        bus.start = 1'b0;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        chk("post_rst_lo", 64'(bus.lo), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
